// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF/MEM word/half/byte requests onto one byte RAM port.
// Define MEM_ARB_RR_EN for round-robin on ties; default is fixed MEM-over-IF.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_len,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_dout,
   output logic              ram_wr,
   input  logic [7:0]        ram_din,
   output logic              stall_req_if,
   output logic              stall_req_mem
);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t            state_q, state_d;
   logic              owner_q;
   logic [1:0]        cnt_q;
   logic [1:0]        last_q;
   logic [1:0]        pidx_q;
   logic              pend_q;
   logic              iss_q;
   logic [ADDR_W-1:0] base_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] buf_q;

   logic              idle_ok;
   logic              gnt_if;
   logic              gnt_mem;
   logic              gnt;
   logic [ADDR_W-1:0] g_addr;
   logic [1:0]        g_last;
   logic              g_we;
   logic [1:0]        len_last;
   logic [1:0]        cnt_inc;
   logic [ADDR_W-1:0] addr_inc;
   logic [DATA_W-1:0] merged;
   logic              rd_last;
   logic              wr_last;

`ifdef MEM_ARB_RR_EN
   logic              last_mem_q;
`endif

   assign stall_req_if  = if_req & ~if_done;
   assign stall_req_mem = mem_req & ~mem_done;

   always_comb begin
      len_last = 2'd3;
      unique case (mem_len)
         2'b00:   len_last = 2'd0;
         2'b01:   len_last = 2'd1;
         default: len_last = 2'd3;
      endcase
   end

   // the done cycle is a dead cycle so a requester can drop req
   always_comb begin
      gnt_if  = 1'b0;
      gnt_mem = 1'b0;
      idle_ok = (state_q == IDLE) & ~(if_done | mem_done);
      if (idle_ok) begin
`ifdef MEM_ARB_RR_EN
         if (mem_req & if_req) begin
            gnt_mem = ~last_mem_q;
            gnt_if  = last_mem_q;
         end else begin
            gnt_mem = mem_req;
            gnt_if  = if_req;
         end
`else
         gnt_mem = mem_req;
         gnt_if  = if_req & ~mem_req;
`endif
      end
      gnt = gnt_if | gnt_mem;
   end

   always_comb begin
      g_addr = gnt_mem ? mem_addr : if_addr;
      g_last = gnt_mem ? len_last : 2'd3;
      g_we   = gnt_mem & mem_we;
   end

   always_comb begin
      cnt_inc  = cnt_q + 2'd1;
      addr_inc = base_q + ADDR_W'(cnt_inc);
      merged   = buf_q | (DATA_W'(ram_din) << {pidx_q, 3'b000});
      rd_last  = pend_q & (pidx_q == last_q);
      wr_last  = (cnt_q == last_q);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (gnt)
               state_d = g_we ? WRITE : READ;
         end
         READ: begin
            if (rd_last)
               state_d = IDLE;
         end
         WRITE: begin
            if (wr_last)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_mem_q <= 1'b1;
      else if (gnt)
         last_mem_q <= gnt_mem;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q   <= 1'b1;
         cnt_q     <= '0;
         last_q    <= '0;
         pidx_q    <= '0;
         pend_q    <= 1'b0;
         iss_q     <= 1'b0;
         base_q    <= '0;
         wdata_q   <= '0;
         buf_q     <= '0;
         ram_addr  <= '0;
         ram_dout  <= '0;
         ram_wr    <= 1'b0;
         if_done   <= 1'b0;
         mem_done  <= 1'b0;
         if_rdata  <= '0;
         mem_rdata <= '0;
      end else begin
         if_done  <= 1'b0;
         mem_done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (gnt) begin
                  owner_q  <= gnt_mem;
                  base_q   <= g_addr;
                  last_q   <= g_last;
                  wdata_q  <= mem_wdata;
                  cnt_q    <= '0;
                  pend_q   <= 1'b0;
                  iss_q    <= 1'b0;
                  buf_q    <= '0;
                  ram_addr <= g_addr;
                  if (g_we) begin
                     ram_dout <= mem_wdata[7:0];
                     ram_wr   <= 1'b1;
                  end
               end
            end
            READ: begin
               // pend marks that ram_din now carries byte pidx
               if (!iss_q) begin
                  pend_q <= 1'b1;
                  pidx_q <= cnt_q;
                  if (cnt_q == last_q) begin
                     iss_q <= 1'b1;
                  end else begin
                     cnt_q    <= cnt_inc;
                     ram_addr <= addr_inc;
                  end
               end else begin
                  pend_q <= 1'b0;
               end
               if (pend_q)
                  buf_q <= merged;
               if (rd_last) begin
                  if (owner_q) begin
                     mem_done  <= 1'b1;
                     mem_rdata <= merged;
                  end else begin
                     if_done  <= 1'b1;
                     if_rdata <= merged;
                  end
               end
            end
            WRITE: begin
               if (wr_last) begin
                  ram_wr <= 1'b0;
                  if (owner_q)
                     mem_done <= 1'b1;
                  else
                     if_done <= 1'b1;
               end else begin
                  cnt_q    <= cnt_inc;
                  ram_addr <= addr_inc;
                  ram_dout <= wdata_q[{cnt_inc, 3'b000} +: 8];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a byte RAM model.
// Expected completions/writes are queued at issue; a negedge monitor checks them.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_len;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic [31:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        ram_wr;
   logic [7:0]  ram_din;
   logic        stall_req_if;
   logic        stall_req_mem;

   typedef struct {
      logic [31:0] data;
      bit          chk;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   exp_t q_if[$];
   exp_t q_mem[$];
   wr_t  q_wr[$];

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   logic [7:0] wmem [logic [31:0]];

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_done(if_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done),
      .ram_addr(ram_addr), .ram_dout(ram_dout),
      .ram_wr(ram_wr), .ram_din(ram_din),
      .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [7:0] pre(input logic [31:0] a);
      case (a)
         32'h0000_0100: pre = 8'h11;
         32'h0000_0101: pre = 8'h22;
         32'h0000_0102: pre = 8'h33;
         32'h0000_0103: pre = 8'h44;
         32'h0000_0200: pre = 8'hAA;
         32'h0000_0201: pre = 8'hBB;
         32'hFFFF_FFFE: pre = 8'h01;
         32'hFFFF_FFFF: pre = 8'h02;
         32'h0000_0000: pre = 8'h03;
         32'h0000_0001: pre = 8'h04;
         default:       pre = a[7:0] ^ 8'h5A;
      endcase
   endfunction

   // synchronous byte RAM: data for an address appears the following cycle
   always @(posedge clk) begin
      if (wmem.exists(ram_addr))
         ram_din <= wmem[ram_addr];
      else
         ram_din <= pre(ram_addr);
      if (ram_wr)
         wmem[ram_addr] = ram_dout;
   end

   function automatic void chk(input string name,
                               input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      wr_t  w;
      if (rst) begin
         if (if_done) begin
            if (q_if.size() == 0) begin
               chk("if_done_unexpected", 1, 0);
            end else begin
               e = q_if.pop_front();
               chk("if_rdata", if_rdata, e.data);
               chk("if_done_cycle", cyc, e.cyc);
            end
         end
         if (mem_done) begin
            if (q_mem.size() == 0) begin
               chk("mem_done_unexpected", 1, 0);
            end else begin
               e = q_mem.pop_front();
               if (e.chk)
                  chk("mem_rdata", mem_rdata, e.data);
               chk("mem_done_cycle", cyc, e.cyc);
            end
         end
         if (ram_wr) begin
            if (q_wr.size() == 0) begin
               chk("ram_wr_unexpected", 1, 0);
            end else begin
               w = q_wr.pop_front();
               chk("ram_wr_addr", ram_addr, w.a);
               chk("ram_wr_data", ram_dout, w.d);
            end
         end
      end
   end

   // stall must be high every cycle until the expected done cycle(s)
   task automatic wait_stall(input bit is_mem, input int d1, input int d2);
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         chk(is_mem ? "stall_req_mem" : "stall_req_if",
             is_mem ? stall_req_mem : stall_req_if,
             (cyc != d1) && (cyc != d2));
         if (cyc >= d2)
            break;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_if(input logic [31:0] a,
                         input logic [31:0] d,
                         input int lat);
      int t0;
      t0 = cyc;
      q_if.push_back('{data: d, chk: 1'b1, cyc: t0 + lat});
      if_addr = a;
      if_req  = 1'b1;
      wait_stall(1'b0, t0 + lat, t0 + lat);
      if_req  = 1'b0;
   endtask

   task automatic run_mem(input logic we, input logic [1:0] len,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int lat);
      int t0;
      int n;
      t0 = cyc;
      n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
      if (we)
         for (int i = 0; i < n; i++)
            q_wr.push_back('{a: a + 32'(i), d: wd[8*i +: 8]});
      q_mem.push_back('{data: rd, chk: !we, cyc: t0 + lat});
      mem_we    = we;
      mem_len   = len;
      mem_addr  = a;
      mem_wdata = wd;
      mem_req   = 1'b1;
      wait_stall(1'b1, t0 + lat, t0 + lat);
      mem_req   = 1'b0;
   endtask

   task automatic summary();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
   endtask

   initial begin : watchdog
      #200000;
      chk("watchdog_timeout", 1, 0);
      summary();
      $finish;
   end

   initial begin : stim
      int t0;
      if_req = 0; if_addr = '0;
      mem_req = 0; mem_we = 0; mem_len = '0;
      mem_addr = '0; mem_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ram_wr", ram_wr, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_dout", ram_dout, 0);
      chk("rst_dones", {if_done, mem_done}, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_mem_rdata", mem_rdata, 0);
      chk("rst_stalls", {stall_req_if, stall_req_mem}, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      run_if(32'h100, 32'h4433_2211, 6);
      run_mem(1'b1, 2'b00, 32'h203, 32'h0000_00AB, 32'h0, 2);
      run_mem(1'b0, 2'b00, 32'h203, 32'h0, 32'h0000_00AB, 3);
      run_mem(1'b1, 2'b01, 32'h501, 32'h0000_1234, 32'h0, 3);
      run_mem(1'b0, 2'b01, 32'h501, 32'h0, 32'h0000_1234, 4);
      run_mem(1'b0, 2'b11, 32'h100, 32'h0, 32'h4433_2211, 6);
      run_mem(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, 32'h0403_0201, 6);

`ifdef MEM_ARB_RR_EN
      fork
         run_mem(1'b0, 2'b01, 32'h200, 32'h0, 32'h0000_BBAA, 11);
         run_if(32'h100, 32'h4433_2211, 6);
      join
`else
      fork
         run_mem(1'b0, 2'b01, 32'h200, 32'h0, 32'h0000_BBAA, 4);
         run_if(32'h100, 32'h4433_2211, 11);
      join
`endif

      // req held through done: regrant only after the dead cycle
      t0 = cyc;
      q_if.push_back('{data: 32'h5958_5B5A, chk: 1'b1, cyc: t0 + 6});
      q_if.push_back('{data: 32'h5958_5B5A, chk: 1'b1, cyc: t0 + 13});
      if_addr = 32'h400;
      if_req  = 1'b1;
      wait_stall(1'b0, t0 + 6, t0 + 13);
      if_req  = 1'b0;

      // reset during the second byte of a word store
      q_wr.push_back('{a: 32'h300, d: 8'hEF});
      mem_we = 1'b1; mem_len = 2'b10;
      mem_addr = 32'h300; mem_wdata = 32'hDEAD_BEEF;
      mem_req = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("abort_ram_wr", ram_wr, 0);
      chk("abort_ram_addr", ram_addr, 0);
      chk("abort_mem_done", mem_done, 0);
      mem_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_no_done", mem_done, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      run_mem(1'b1, 2'b10, 32'h300, 32'hDEAD_BEEF, 32'h0, 5);
      run_mem(1'b0, 2'b10, 32'h300, 32'h0, 32'hDEAD_BEEF, 6);

      repeat (4) @(posedge clk);
      #1;
      chk("q_if_left", q_if.size(), 0);
      chk("q_mem_left", q_mem.size(), 0);
      chk("q_wr_left", q_wr.size(), 0);
      summary();
      $finish;
   end

endmodule
